// File: rtl/chess_timer_pkg.sv
// Shared chess-clock definitions used by the seconds stage, the minutes stage
// and the turn controller.
//   state_e      : per-player clock state encoding (ST_IDLE..ST_EXPIRED)
//   MIN_W_DEF    : default width of the minutes count
//   MAX_MIN_DEF  : default displayable maximum of the minutes count
package chess_timer_pkg;

    localparam int unsigned MIN_W_DEF   = 7;
    localparam int unsigned MAX_MIN_DEF = 99;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

endpackage : chess_timer_pkg

// File: rtl/minutes_countdown_if.sv
// Minutes-stage signal bundle between the seconds stage / controller (master)
// and the minutes countdown (slave).
//   sec_carry  : toggle carry from the seconds stage (master -> slave)
//   run        : level, this player's clock is running (master -> slave)
//   load       : 1-cycle load pulse (master -> slave)
//   load_min   : minutes value to load (master -> slave)
//   minutes    : remaining minutes (slave -> master)
//   min_tick   : 1-cycle pulse per accepted decrement (slave -> master)
//   flag_fall  : sticky time-expired flag (slave -> master)
//   state      : clock state (slave -> master)
//   low_time   : low-time warning, only with MINCNT_LOWTIME_EN (slave -> master)
interface minutes_countdown_if
    import chess_timer_pkg::*;
#(
    parameter int unsigned MIN_W = MIN_W_DEF
);

    logic             sec_carry;
    logic             run;
    logic             load;
    logic [MIN_W-1:0] load_min;
    logic [MIN_W-1:0] minutes;
    logic             min_tick;
    logic             flag_fall;
    state_e           state;
`ifdef MINCNT_LOWTIME_EN
    logic             low_time;
`endif

    modport master (
        output sec_carry, run, load, load_min,
`ifdef MINCNT_LOWTIME_EN
        input  low_time,
`endif
        input  minutes, min_tick, flag_fall, state
    );

    modport slave (
        input  sec_carry, run, load, load_min,
`ifdef MINCNT_LOWTIME_EN
        output low_time,
`endif
        output minutes, min_tick, flag_fall, state
    );

endinterface : minutes_countdown_if

// File: rtl/toggle_edge_detect.sv
// Converts a toggle-type carry into a one-cycle pulse per level change.
// The history register follows din every cycle, so it is always in sync with
// the input; clear (and reset) only suppress the pulse for the cycle in which
// they are asserted, which discards any change seen in that cycle.
//   clk    : clock
//   reset  : synchronous, active-high
//   clear  : resync request, masks the pulse this cycle
//   din    : toggle input
//   pulse  : combinational, 1 when din differs from its previous value
module toggle_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // History register; tracks din in every state, including reset.
    always_ff @(posedge clk) begin
        din_q <= din;
    end

    assign pulse = (din ^ din_q) & ~clear & ~reset;

endmodule : toggle_edge_detect

// File: rtl/minutes_countdown.sv
// Minutes stage of one player's chess clock. Each level change on the seconds
// stage's toggle carry decrements the minutes while running; wrapping at zero
// minutes raises a sticky flag-fall and parks the clock in EXPIRED.
// Optional feature macro: MINCNT_LOWTIME_EN (adds low_time and WARN_MIN).
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : minutes_countdown_if.slave (sec_carry, run, load, load_min in;
//            minutes, min_tick, flag_fall, state[, low_time] out, all registered)
module minutes_countdown
    import chess_timer_pkg::*;
#(
    parameter int unsigned MIN_W    = MIN_W_DEF,
    parameter int unsigned INIT_MIN = 10,
    parameter int unsigned MAX_MIN  = MAX_MIN_DEF
`ifdef MINCNT_LOWTIME_EN
    ,
    parameter int unsigned WARN_MIN = 1
`endif
) (
    input  logic                clk,
    input  logic                reset,
    minutes_countdown_if.slave  bus
);

    localparam int unsigned     RST_MIN = (INIT_MIN > MAX_MIN) ? MAX_MIN : INIT_MIN;
    localparam logic [MIN_W-1:0] RST_VAL = MIN_W'(RST_MIN);
    localparam logic [MIN_W-1:0] MAX_VAL = MIN_W'(MAX_MIN);

    state_e           state_q,   state_n;
    logic [MIN_W-1:0] minutes_q, minutes_n;
    logic             tick_q,    tick_n;
    logic             flag_q,    flag_n;
    logic             wrap_c;
    logic [MIN_W-1:0] load_sat_c;

    // Carry edge detector; a load discards a wrap arriving in the same cycle.
    toggle_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .clear (bus.load),
        .din   (bus.sec_carry),
        .pulse (wrap_c)
    );

    // Saturating loader keeps minutes within the displayable range.
    assign load_sat_c = (bus.load_min > MAX_VAL) ? MAX_VAL : bus.load_min;

    // Next-state, decrementer and flag logic; priority load > wrap > run.
    always_comb begin
        state_n   = state_q;
        minutes_n = minutes_q;
        tick_n    = 1'b0;
        flag_n    = flag_q;

        if (bus.load) begin
            state_n   = ST_IDLE;
            minutes_n = load_sat_c;
            flag_n    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.run) state_n = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (wrap_c) begin
                        if (minutes_q != '0) begin
                            minutes_n = minutes_q - MIN_W'(1);
                            tick_n    = 1'b1;
                            if (!bus.run) state_n = ST_PAUSED;
                        end else begin
                            // Out of time: hold at zero, no underflow.
                            flag_n  = 1'b1;
                            state_n = ST_EXPIRED;
                        end
                    end else if (!bus.run) begin
                        state_n = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.run) state_n = ST_RUNNING;
                end
                ST_EXPIRED: begin
                    state_n = ST_EXPIRED;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            minutes_q <= RST_VAL;
            tick_q    <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            minutes_q <= minutes_n;
            tick_q    <= tick_n;
            flag_q    <= flag_n;
        end
    end

    assign bus.minutes   = minutes_q;
    assign bus.min_tick  = tick_q;
    assign bus.flag_fall = flag_q;
    assign bus.state     = state_q;

`ifdef MINCNT_LOWTIME_EN
    localparam logic [MIN_W-1:0] WARN_VAL = MIN_W'(WARN_MIN);

    logic low_q;
    logic low_n;

    // Warning follows the registered count, so it trails minutes by one clock.
    always_comb begin
        low_n = 1'b0;
        if ((state_q == ST_RUNNING) || (state_q == ST_PAUSED)) begin
            low_n = (minutes_q < WARN_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            low_q <= 1'b0;
        end else begin
            low_q <= low_n;
        end
    end

    assign bus.low_time = low_q;
`endif

endmodule : minutes_countdown

// File: tb/tb_minutes_countdown.sv
// Directed bench for minutes_countdown with default parameters
// (MIN_W=7, INIT_MIN=10, MAX_MIN=99). Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 time unit after the following edge.
module tb_minutes_countdown;
    import chess_timer_pkg::*;

    localparam int unsigned MIN_W = 7;

    logic clk;
    logic reset;
    int   vectors;
    int   fails;

    minutes_countdown_if #(.MIN_W(MIN_W)) bus ();

    minutes_countdown #(
        .MIN_W    (MIN_W),
        .INIT_MIN (10),
        .MAX_MIN  (99)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int m, input int tk, input int fl, input int st);
        chk({tag, ".minutes"},   32'(bus.minutes),   32'(m));
        chk({tag, ".min_tick"},  32'(bus.min_tick),  32'(tk));
        chk({tag, ".flag_fall"}, 32'(bus.flag_fall), 32'(fl));
        chk({tag, ".state"},     32'(bus.state),     32'(st));
    endtask

    task automatic toggle();
        bus.sec_carry = ~bus.sec_carry;
    endtask

    initial begin
        vectors       = 0;
        fails         = 0;
        reset         = 1'b1;
        bus.sec_carry = 1'b0;
        bus.run       = 1'b0;
        bus.load      = 1'b0;
        bus.load_min  = '0;

        // 1. Reset state, then wraps in IDLE are ignored.
        tick();
        tick();
        chk_out("reset", 10, 0, 0, 0);
        reset = 1'b0;
        toggle();
        tick();
        chk_out("idle_wrap", 10, 0, 0, 0);
        toggle();
        tick();
        chk_out("idle_wrap2", 10, 0, 0, 0);

        // 2. Run and count down 10 -> 7, one tick per toggle, 1 clk latency.
        bus.run = 1'b1;
        tick();
        chk_out("start", 10, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            toggle();
            tick();
            chk_out($sformatf("dec%0d", i), 10 - i, 1, 0, 1);
            tick();
            chk_out($sformatf("dec%0d_after", i), 10 - i, 0, 0, 1);
        end

        // 4. Pause, wraps discarded, resume without back-decrement.
        bus.run = 1'b0;
        tick();
        chk_out("pause", 7, 0, 0, 2);
        toggle();
        tick();
        chk_out("pause_wrap1", 7, 0, 0, 2);
        toggle();
        tick();
        chk_out("pause_wrap2", 7, 0, 0, 2);
        bus.run = 1'b1;
        tick();
        chk_out("resume", 7, 0, 0, 1);
        tick();
        chk_out("resume_hold", 7, 0, 0, 1);

        // 3. Load 2, count to zero, expire, stay expired.
        bus.load_min = 7'd2;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        chk_out("load2", 2, 0, 0, 0);
        tick();
        chk_out("load2_run", 2, 0, 0, 1);
        toggle();
        tick();
        chk_out("to1", 1, 1, 0, 1);
        toggle();
        tick();
        chk_out("to0", 0, 1, 0, 1);
        toggle();
        tick();
        chk_out("expire", 0, 0, 1, 3);
        toggle();
        tick();
        chk_out("expired_wrap", 0, 0, 1, 3);
        bus.run = 1'b0;
        tick();
        chk_out("expired_run0", 0, 0, 1, 3);

        // 5. Saturating load out of EXPIRED clears the flag.
        bus.load_min = 7'd120;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        chk_out("load120", 99, 0, 0, 0);
        bus.load_min = 7'd99;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        chk_out("load99", 99, 0, 0, 0);
        bus.run = 1'b1;
        tick();
        chk_out("run99", 99, 0, 0, 1);

        // Load and wrap in the same cycle: load wins, wrap discarded.
        bus.load_min = 7'd5;
        bus.load     = 1'b1;
        toggle();
        tick();
        bus.load     = 1'b0;
        chk_out("load_wrap", 5, 0, 0, 0);
        tick();
        chk_out("load_wrap_after", 5, 0, 0, 1);

        // Wrap and run=0 together while RUNNING: decrement, then PAUSED.
        toggle();
        bus.run = 1'b0;
        tick();
        chk_out("wrap_pause", 4, 1, 0, 2);
        tick();
        chk_out("wrap_pause_after", 4, 0, 0, 2);

        // Synchronous reset mid-game restores INIT_MIN.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("reset2", 10, 0, 0, 0);

`ifdef MINCNT_LOWTIME_EN
        // 6. Low-time warning trails minutes by one clock, clears on EXPIRED.
        bus.load_min = 7'd1;
        bus.load     = 1'b1;
        bus.run      = 1'b1;
        tick();
        bus.load     = 1'b0;
        chk("lt_idle", 32'(bus.low_time), 32'd0);
        tick();
        chk("lt_run1", 32'(bus.low_time), 32'd0);
        toggle();
        tick();
        chk_out("lt_to0", 0, 1, 0, 1);
        chk("lt_same", 32'(bus.low_time), 32'd0);
        tick();
        chk("lt_set", 32'(bus.low_time), 32'd1);
        toggle();
        tick();
        chk_out("lt_expire", 0, 0, 1, 3);
        tick();
        chk("lt_clear", 32'(bus.low_time), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_minutes_countdown
